// File: rtl/holosynth_midi_pkg.sv
// Shared MIDI definitions: status constants, message-length decode, FSM states.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package holosynth_midi_pkg;

  localparam logic [7:0] NOTE_OFF         = 8'h80;
  localparam logic [7:0] NOTE_ON          = 8'h90;
  localparam logic [7:0] POLY_PRESSURE    = 8'hA0;
  localparam logic [7:0] CONTROL_CHANGE   = 8'hB0;
  localparam logic [7:0] PROGRAM_CHANGE   = 8'hC0;
  localparam logic [7:0] CHANNEL_PRESSURE = 8'hD0;
  localparam logic [7:0] PITCH_BEND       = 8'hE0;
  localparam logic [7:0] SYSEX_START      = 8'hF0;
  localparam logic [7:0] MTC_QUARTER      = 8'hF1;
  localparam logic [7:0] SONG_POSITION    = 8'hF2;
  localparam logic [7:0] SONG_SELECT      = 8'hF3;
  localparam logic [7:0] TUNE_REQUEST     = 8'hF6;
  localparam logic [7:0] SYSEX_END        = 8'hF7;
  localparam logic [7:0] TIMING_CLOCK     = 8'hF8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_t;

  // 80..EF: voice/mode messages that take part in running status.
  function automatic logic is_channel_msg(input logic [7:0] s);
    return s[7] && (s[6:4] != 3'b111);
  endfunction

  // F8..FF: single-byte real-time messages.
  function automatic logic is_realtime(input logic [7:0] s);
    return s[7:3] == 5'b11111;
  endfunction

  // Full wire length of a message including its status byte; 0 = not a status.
  function automatic logic [1:0] midi_msg_len(input logic [7:0] s);
    logic [1:0] len;
    len = 2'd0;
    if (!s[7]) begin
      len = 2'd0;
    end else if (is_realtime(s)) begin
      len = 2'd1;
    end else begin
      case (s[7:4])
        4'hC, 4'hD: len = 2'd2;
        4'hF: begin
          case (s[3:0])
            4'h1, 4'h3: len = 2'd2;
            4'h2:       len = 2'd3;
            default:    len = 2'd1;
          endcase
        end
        default: len = 2'd3;
      endcase
    end
    return len;
  endfunction

endpackage

// File: rtl/midi_uart_tx_byte.sv
// 8N1 byte serialiser; each bit is DIV clocks, start bit driven the cycle after start.
// Latency: 1 clock from start to start bit; done marks the last stop-bit clock.
// Backpressure: none; a start on the done cycle chains the next frame with no idle.
module midi_uart_tx_byte #(
  parameter int DIV = 1600
) (
  input  logic       reg_clk,
  input  logic       reset_reg,
  input  logic       start,
  input  logic [7:0] data,
  output logic       done,
  output logic       bit_end,
  output logic       txd
);

  localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic          r_active;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bitn;   // 0 = start, 1..8 = data, 9 = stop
  logic [8:0]    r_shift;  // stop bit parked above the data so it shifts out last
  logic          r_txd;

  assign bit_end = r_active && (r_cnt == CNT_LAST);
  assign done    = bit_end && (r_bitn == 4'd9);
  assign txd     = r_txd;

  // Baud counter and shift register; line level is registered for a glitch-free pin.
  always_ff @(posedge reg_clk) begin
    if (reset_reg) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_bitn   <= 4'd0;
      r_shift  <= '1;
      r_txd    <= 1'b1;
    end else if (start) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
      r_bitn   <= 4'd0;
      r_shift  <= {1'b1, data};
      r_txd    <= 1'b0;
    end else if (bit_end) begin
      r_cnt <= '0;
      if (r_bitn == 4'd9) begin
        r_active <= 1'b0;
      end else begin
        r_bitn  <= r_bitn + 4'd1;
        r_txd   <= r_shift[0];
        r_shift <= {1'b1, r_shift[8:1]};
      end
    end else if (r_active) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/midi_tx_encoder.sv
// MIDI message encoder: running-status compression, length decode, 8N1 serial out.
// Latency: accept at T, LOAD at T+1, start bit on the line from T+2.
// Backpressure: msg_ready is high only while idle; one message in flight at a time.
module midi_tx_encoder #(
  parameter int REG_CLK_FREQUENCY = 50_000_000,
  parameter int BAUD              = 31250,
  parameter int RUNNING_STATUS    = 1,
  parameter int Invert_txd        = 0
) (
  input  logic       reg_clk,
  input  logic       reset_reg,
  input  logic       msg_valid,
  output logic       msg_ready,
  input  logic [7:0] msg_status,
  input  logic [6:0] msg_data1,
  input  logic [6:0] msg_data2,
  input  logic       rs_clear,
  output logic       midi_txd,
  output logic       busy,
  output logic       err
);
  import holosynth_midi_pkg::*;

  localparam int DIV = REG_CLK_FREQUENCY / BAUD;

  tx_state_t       r_state;
  logic            r_ready;
  logic            r_busy;
  logic            r_err;
  logic [7:0]      r_status;
  logic [6:0]      r_d1;
  logic [6:0]      r_d2;
  logic [7:0]      r_rs;        // running status, 00 = none
  logic [2:0][7:0] r_bytes;
  logic [1:0]      r_count;
  logic [1:0]      r_byte_idx;
  logic [2:0]      r_bit_idx;

  logic [1:0]      w_len;
  logic            w_skip;
  logic [1:0]      w_count;
  logic [2:0][7:0] w_bytes;
  logic [1:0]      w_next_idx;
  logic            w_more;
  logic [7:0]      w_next_byte;
  logic            w_start;
  logic [7:0]      w_tx_byte;
  logic            w_done;
  logic            w_bit_end;
  logic            w_txd;

  // Byte list for the latched message; status is dropped when it repeats running status.
  always_comb begin
    w_len   = midi_msg_len(r_status);
    w_skip  = (RUNNING_STATUS != 0) && is_channel_msg(r_status) && (r_status == r_rs);
    w_count = w_len;
    w_bytes = {{1'b0, r_d2}, {1'b0, r_d1}, r_status};
    if (w_skip) begin
      w_count = w_len - 2'd1;
      w_bytes = {8'h00, {1'b0, r_d2}, {1'b0, r_d1}};
    end
  end

  // Next byte to hand the serialiser: first byte from LOAD, later ones from the stored list.
  always_comb begin
    w_next_idx = r_byte_idx + 2'd1;
    w_more     = (w_next_idx < r_count);
    case (w_next_idx)
      2'd1:    w_next_byte = r_bytes[1];
      2'd2:    w_next_byte = r_bytes[2];
      default: w_next_byte = r_bytes[0];
    endcase
    w_start   = ((r_state == ST_LOAD) && (w_count != 2'd0)) ||
                ((r_state == ST_STOP) && w_done && w_more);
    w_tx_byte = (r_state == ST_LOAD) ? w_bytes[0] : w_next_byte;
  end

  midi_uart_tx_byte #(.DIV(DIV)) u_byte (
    .reg_clk   (reg_clk),
    .reset_reg (reset_reg),
    .start     (w_start),
    .data      (w_tx_byte),
    .done      (w_done),
    .bit_end   (w_bit_end),
    .txd       (w_txd)
  );

  // Control FSM: handshake, byte sequencing and running-status bookkeeping.
  always_ff @(posedge reg_clk) begin
    if (reset_reg) begin
      r_state    <= ST_IDLE;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_status   <= 8'h00;
      r_d1       <= 7'h00;
      r_d2       <= 7'h00;
      r_rs       <= 8'h00;
      r_bytes    <= '0;
      r_count    <= 2'd0;
      r_byte_idx <= 2'd0;
      r_bit_idx  <= 3'd0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (msg_valid && r_ready) begin
            r_status <= msg_status;
            r_d1     <= msg_data1;
            r_d2     <= msg_data2;
            r_err    <= ~msg_status[7];
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= ST_LOAD;
          end else begin
            r_ready <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_bytes    <= w_bytes;
          r_count    <= w_count;
          r_byte_idx <= 2'd0;
          // Real-time leaves running status alone; system common/exclusive cancels it.
          if (is_channel_msg(r_status)) begin
            r_rs <= r_status;
          end else if (r_status[7] && !is_realtime(r_status)) begin
            r_rs <= 8'h00;
          end
          if (w_count == 2'd0) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_state   <= ST_DATA;
            r_bit_idx <= 3'd0;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == 3'd7) r_state <= ST_STOP;
            else                   r_bit_idx <= r_bit_idx + 3'd1;
          end
        end
        ST_STOP: begin
          if (w_done) begin
            if (w_more) begin
              r_state    <= ST_START;
              r_byte_idx <= w_next_idx;
            end else begin
              r_state <= ST_IDLE;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // A clear in the accept cycle lands before LOAD compares, so the status is sent.
      if (rs_clear) r_rs <= 8'h00;
    end
  end

  assign msg_ready = r_ready;
  assign busy      = r_busy;
  assign err       = r_err;
  assign midi_txd  = (Invert_txd != 0) ? ~w_txd : w_txd;

endmodule

// File: tb/tb_midi_tx_encoder.sv
module tb_midi_tx_encoder;
  localparam int DIV = 16;

  logic       reg_clk = 1'b0;
  logic       reset_reg = 1'b1;
  logic       msg_valid = 1'b0;
  logic [7:0] msg_status = 8'h00;
  logic [6:0] msg_data1 = 7'h00;
  logic [6:0] msg_data2 = 7'h00;
  logic       rs_clear = 1'b0;
  logic       msg_ready, midi_txd, busy, err;
  logic       ready_i, txd_i, busy_i, err_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 reg_clk = ~reg_clk;

  initial forever begin
    @(posedge reg_clk);
    cyc++;
  end

  midi_tx_encoder #(.REG_CLK_FREQUENCY(16), .BAUD(1), .RUNNING_STATUS(1), .Invert_txd(0)) u_dut (
    .reg_clk(reg_clk), .reset_reg(reset_reg), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_status(msg_status), .msg_data1(msg_data1), .msg_data2(msg_data2), .rs_clear(rs_clear),
    .midi_txd(midi_txd), .busy(busy), .err(err));

  midi_tx_encoder #(.REG_CLK_FREQUENCY(16), .BAUD(1), .RUNNING_STATUS(1), .Invert_txd(1)) u_dut_inv (
    .reg_clk(reg_clk), .reset_reg(reset_reg), .msg_valid(msg_valid), .msg_ready(ready_i),
    .msg_status(msg_status), .msg_data1(msg_data1), .msg_data2(msg_data2), .rs_clear(rs_clear),
    .midi_txd(txd_i), .busy(busy_i), .err(err_i));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, expv);
    end
  endtask

  // Scoreboard: expected wire bytes per line (plain and inverted instance).
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  task automatic push_exp(input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    if (n > 0) begin exp_q0.push_back(b0); exp_q1.push_back(b0); end
    if (n > 1) begin exp_q0.push_back(b1); exp_q1.push_back(b1); end
    if (n > 2) begin exp_q0.push_back(b2); exp_q1.push_back(b2); end
  endtask

  // UART receiver monitors, sampling mid-bit on the falling edge.
  logic       m_act[2];
  int         m_cnt[2];
  logic [7:0] m_sh[2];
  logic       m_sbit[2];

  task automatic mon_step(input int id, input logic line);
    int c;
    logic [7:0] e;
    if (reset_reg) begin
      m_act[id] = 1'b0;
    end else if (!m_act[id]) begin
      if (line == 1'b0) begin
        m_act[id] = 1'b1;
        m_cnt[id] = 1;
      end
    end else begin
      c = m_cnt[id];
      if (c == DIV / 2) begin
        m_sbit[id] = line;
      end else if (c == 9 * DIV + DIV / 2) begin
        if ((id == 0 && exp_q0.size() == 0) || (id == 1 && exp_q1.size() == 0)) begin
          checks++;
          errors++;
          $display("FAIL wire%0d_unexpected: got byte %0h, required no byte", id, m_sh[id]);
        end else begin
          e = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          chk($sformatf("wire%0d_frame", id), {22'd0, m_sbit[id], line, m_sh[id]}, {22'd0, 1'b0, 1'b1, e});
        end
        m_act[id] = 1'b0;
      end else if ((c % DIV) == DIV / 2 && c / DIV >= 1 && c / DIV <= 8) begin
        m_sh[id][c / DIV - 1] = line;
      end
      m_cnt[id] = c + 1;
    end
  endtask

  initial begin
    m_act[0] = 1'b0;
    m_act[1] = 1'b0;
    forever begin
      @(negedge reg_clk);
      mon_step(0, midi_txd);
      mon_step(1, ~txd_i);
    end
  end

  // Offer a message at a falling edge once ready; t is the handshake cycle.
  task automatic send(input logic [7:0] st, input logic [6:0] a, input logic [6:0] b,
                      input logic clr, output int t);
    int g;
    g = 0;
    @(negedge reg_clk);
    while (msg_ready !== 1'b1 && g < 1000) begin
      @(negedge reg_clk);
      g++;
    end
    if (msg_ready !== 1'b1) chk("send_ready_timeout", 32'(msg_ready), 32'd1);
    msg_valid  = 1'b1;
    msg_status = st;
    msg_data1  = a;
    msg_data2  = b;
    rs_clear   = clr;
    t = cyc;
    @(negedge reg_clk);
    msg_valid = 1'b0;
    rs_clear  = 1'b0;
  endtask

  task automatic wait_ready(input int t, input int n, input string name);
    int g;
    logic pb;
    g = 0;
    pb = busy;
    while (msg_ready !== 1'b1 && g < 1000) begin
      pb = busy;
      @(negedge reg_clk);
      g++;
    end
    chk(name, 32'(cyc - t), 32'(2 + 10 * n * DIV));
    chk({name, "_inv"}, 32'(ready_i), 32'd1);
    if (n > 0) chk({name, "_busy"}, {30'd0, pb, busy}, 32'b10);
  endtask

  typedef struct {
    logic [7:0] st;
    logic [6:0] d1;
    logic [6:0] d2;
    int         n;
    logic [7:0] e0;
    logic [7:0] e1;
    logic [7:0] e2;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] st, input logic [6:0] d1, input logic [6:0] d2,
                              input int n, input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    vec_t v;
    v.st = st; v.d1 = d1; v.d2 = d2; v.n = n; v.e0 = e0; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    int t;
    vec_t v;

    // Running status is 90 when the table starts.
    tbl.push_back(mk(8'h90, 7'h40, 7'h00, 2, 8'h40, 8'h00, 8'h00));
    tbl.push_back(mk(8'h80, 7'h3C, 7'h00, 3, 8'h80, 8'h3C, 8'h00));
    tbl.push_back(mk(8'h90, 7'h3C, 7'h64, 3, 8'h90, 8'h3C, 8'h64));
    tbl.push_back(mk(8'hF8, 7'h11, 7'h22, 1, 8'hF8, 8'h00, 8'h00));
    tbl.push_back(mk(8'h90, 7'h3E, 7'h64, 2, 8'h3E, 8'h64, 8'h00));
    tbl.push_back(mk(8'hF2, 7'h01, 7'h02, 3, 8'hF2, 8'h01, 8'h02));
    tbl.push_back(mk(8'h90, 7'h3E, 7'h00, 3, 8'h90, 8'h3E, 8'h00));
    tbl.push_back(mk(8'hC3, 7'h05, 7'h33, 2, 8'hC3, 8'h05, 8'h00));
    tbl.push_back(mk(8'hC3, 7'h06, 7'h33, 1, 8'h06, 8'h00, 8'h00));
    tbl.push_back(mk(8'hD1, 7'h7F, 7'h00, 2, 8'hD1, 8'h7F, 8'h00));
    tbl.push_back(mk(8'hA2, 7'h11, 7'h22, 3, 8'hA2, 8'h11, 8'h22));
    tbl.push_back(mk(8'hB0, 7'h07, 7'h7F, 3, 8'hB0, 8'h07, 8'h7F));
    tbl.push_back(mk(8'hE5, 7'h00, 7'h40, 3, 8'hE5, 8'h00, 8'h40));
    tbl.push_back(mk(8'hF1, 7'h12, 7'h34, 2, 8'hF1, 8'h12, 8'h00));
    tbl.push_back(mk(8'hF3, 7'h05, 7'h00, 2, 8'hF3, 8'h05, 8'h00));
    tbl.push_back(mk(8'hE5, 7'h01, 7'h02, 3, 8'hE5, 8'h01, 8'h02));
    tbl.push_back(mk(8'hFE, 7'h00, 7'h00, 1, 8'hFE, 8'h00, 8'h00));
    tbl.push_back(mk(8'hE5, 7'h03, 7'h04, 2, 8'h03, 8'h04, 8'h00));
    tbl.push_back(mk(8'hF6, 7'h00, 7'h00, 1, 8'hF6, 8'h00, 8'h00));
    tbl.push_back(mk(8'hF0, 7'h00, 7'h00, 1, 8'hF0, 8'h00, 8'h00));
    tbl.push_back(mk(8'hF7, 7'h00, 7'h00, 1, 8'hF7, 8'h00, 8'h00));
    tbl.push_back(mk(8'h91, 7'h70, 7'h7F, 3, 8'h91, 8'h70, 8'h7F));

    // Reset state.
    repeat (3) @(negedge reg_clk);
    chk("rst_txd", 32'(midi_txd), 32'd1);
    chk("rst_txd_inv", 32'(txd_i), 32'd0);
    chk("rst_ready", {29'd0, msg_ready, ready_i, 1'b0}, 32'd0);
    chk("rst_busy", {30'd0, busy, busy_i}, 32'd0);
    chk("rst_err", {30'd0, err, err_i}, 32'd0);
    reset_reg = 1'b0;
    @(negedge reg_clk);
    chk("rst_release_ready", 32'(msg_ready), 32'd1);

    // Note-on after reset with exact timing.
    push_exp(3, 8'h90, 8'h3C, 8'h64);
    send(8'h90, 7'h3C, 7'h64, 1'b0, t);
    chk("t1_load_line_idle", 32'(midi_txd), 32'd1);
    chk("t1_load_busy", 32'(busy), 32'd1);
    @(negedge reg_clk);
    chk("t1_start_bit", {30'd0, midi_txd, txd_i}, 32'b01);
    wait_ready(t, 3, "t1_ready");

    // Table of messages: length decode and running status.
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      push_exp(v.n, v.e0, v.e1, v.e2);
      send(v.st, v.d1, v.d2, 1'b0, t);
      wait_ready(t, v.n, $sformatf("vec%0d_ready", i));
    end

    // Invalid status: err pulse, nothing on the wire.
    send(8'h45, 7'h01, 7'h02, 1'b0, t);
    chk("inv_err", {30'd0, err, err_i}, 32'b11);
    chk("inv_line", 32'(midi_txd), 32'd1);
    wait_ready(t, 0, "inv_ready");
    chk("inv_err_clear", 32'(err), 32'd0);
    chk("inv_line2", 32'(midi_txd), 32'd1);

    // rs_clear in the accept cycle forces the repeated status out.
    push_exp(2, 8'hC0, 8'h05, 8'h00);
    send(8'hC0, 7'h05, 7'h00, 1'b0, t);
    wait_ready(t, 2, "rsc_first_ready");
    push_exp(2, 8'hC0, 8'h07, 8'h00);
    send(8'hC0, 7'h07, 7'h00, 1'b1, t);
    wait_ready(t, 2, "rsc_second_ready");

    // Reset during bit 3 of the first data byte; only the status byte completes.
    push_exp(1, 8'h90, 8'h00, 8'h00);
    send(8'h90, 7'h3C, 7'h64, 1'b0, t);
    while (cyc < t + 230) @(negedge reg_clk);
    reset_reg = 1'b1;
    @(negedge reg_clk);
    chk("mid_rst_txd", {30'd0, midi_txd, txd_i}, 32'b10);
    chk("mid_rst_ready", 32'(msg_ready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    reset_reg = 1'b0;
    @(negedge reg_clk);
    chk("mid_rst_release_ready", {30'd0, msg_ready, ready_i}, 32'b11);
    push_exp(3, 8'h90, 8'h40, 8'h00);
    send(8'h90, 7'h40, 7'h00, 1'b0, t);
    wait_ready(t, 3, "post_rst_ready");

    repeat (40) @(negedge reg_clk);
    chk("q0_drained", 32'(exp_q0.size()), 32'd0);
    chk("q1_drained", 32'(exp_q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
